// File: rtl/core_branch_pkg.sv
// Shared branch-resolution definitions: funct3 encodings, FSM state type and default widths.
package core_branch_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned CNT_W_DEFAULT = 32;
    localparam int unsigned F3_W = 3;

    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        BR_IDLE     = 1'b0,
        BR_REDIRECT = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_cond_decode.sv
// Combinational condition decode: maps branch funct3 and comparator flags to taken/illegal.
module branch_cond_decode
    import core_branch_pkg::*;
(
    input  logic [F3_W-1:0] funct3,
    input  logic            lsr,
    input  logic            lsru,
    input  logic            eql,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eql;
            F3_BNE:  taken = !eql;
            F3_BLT:  taken = lsr;
            F3_BGE:  taken = !lsr;
            F3_BLTU: taken = lsru;
            F3_BGEU: taken = !lsru;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution: taken decision, target/link generation,
// registered redirect+flush handshake to fetch, and branch performance counters.
module branch_resolve_unit
    import core_branch_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid_i,
    input  logic             ex_is_branch_i,
    input  logic             ex_is_jal_i,
    input  logic             ex_is_jalr_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic [XLEN-1:0]  ex_imm_i,
    input  logic [XLEN-1:0]  ex_rs1_i,
    input  logic             lsr_i,
    input  logic             lsrU_i,
    input  logic             eql_i,
    input  logic             if_redirect_ready_i,
    output logic             ex_stall_o,
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_o,
    output logic             link_valid_o,
    output logic [XLEN-1:0]  link_wdata_o,
    output logic             misalign_exc_o,
    output logic [XLEN-1:0]  misalign_addr_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] perf_branch_cnt_o,
    output logic [CNT_W-1:0] perf_taken_cnt_o
);

    br_state_e        state_q, state_d;
    logic             redirect_valid_d, flush_d, link_valid_d, misalign_d, illegal_d;
    logic [XLEN-1:0]  redirect_pc_d, link_wdata_d, misalign_addr_d;
    logic [CNT_W-1:0] branch_cnt_d, taken_cnt_d;

    logic             cond_taken, cond_illegal;
    logic             is_jalr, is_jal, is_br, accept, taken, aligned;
    logic [XLEN-1:0]  jalr_sum, target;

    branch_cond_decode u_cond (
        .funct3  (ex_funct3_i),
        .lsr     (lsr_i),
        .lsru    (lsrU_i),
        .eql     (eql_i),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    // Kind priority JALR > JAL > branch; JALR target has bit0 forced low.
    assign is_jalr  = ex_is_jalr_i;
    assign is_jal   = !ex_is_jalr_i && ex_is_jal_i;
    assign is_br    = !ex_is_jalr_i && !ex_is_jal_i && ex_is_branch_i;
    assign jalr_sum = ex_rs1_i + ex_imm_i;
    assign target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc_i + ex_imm_i);
    assign taken    = is_jalr || is_jal || (is_br && cond_taken);
    assign aligned  = (target[1:0] == 2'b00);
    assign accept   = (state_q == BR_IDLE) && ex_valid_i
                      && (ex_is_branch_i || ex_is_jal_i || ex_is_jalr_i);

    assign ex_stall_o = (state_q == BR_REDIRECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= BR_IDLE;
            redirect_valid_o  <= 1'b0;
            redirect_pc_o     <= '0;
            flush_o           <= 1'b0;
            link_valid_o      <= 1'b0;
            link_wdata_o      <= '0;
            misalign_exc_o    <= 1'b0;
            misalign_addr_o   <= '0;
            illegal_o         <= 1'b0;
            perf_branch_cnt_o <= '0;
            perf_taken_cnt_o  <= '0;
        end else begin
            state_q           <= state_d;
            redirect_valid_o  <= redirect_valid_d;
            redirect_pc_o     <= redirect_pc_d;
            flush_o           <= flush_d;
            link_valid_o      <= link_valid_d;
            link_wdata_o      <= link_wdata_d;
            misalign_exc_o    <= misalign_d;
            misalign_addr_o   <= misalign_addr_d;
            illegal_o         <= illegal_d;
            perf_branch_cnt_o <= branch_cnt_d;
            perf_taken_cnt_o  <= taken_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = redirect_valid_o;
        redirect_pc_d    = redirect_pc_o;
        flush_d          = 1'b0;
        link_valid_d     = 1'b0;
        link_wdata_d     = link_wdata_o;
        misalign_d       = 1'b0;
        misalign_addr_d  = misalign_addr_o;
        illegal_d        = 1'b0;
        branch_cnt_d     = perf_branch_cnt_o;
        taken_cnt_d      = perf_taken_cnt_o;

        case (state_q)
            BR_IDLE: begin
                redirect_valid_d = 1'b0;
                if (accept) begin
                    if (is_br && cond_illegal) begin
                        illegal_d = 1'b1;
                    end else begin
                        if (is_br) begin
                            branch_cnt_d = perf_branch_cnt_o + CNT_W'(1);
                        end
                        if (taken && !aligned) begin
                            misalign_d      = 1'b1;
                            misalign_addr_d = target;
                        end else if (taken) begin
                            state_d          = BR_REDIRECT;
                            redirect_valid_d = 1'b1;
                            redirect_pc_d    = target;
                            flush_d          = 1'b1;
                            taken_cnt_d      = perf_taken_cnt_o + CNT_W'(1);
                            if (is_jal || is_jalr) begin
                                link_valid_d = 1'b1;
                                link_wdata_d = ex_pc_i + XLEN'(4);
                            end
                        end
                    end
                end
            end
            BR_REDIRECT: begin
                // Hold request stable until fetch takes it.
                if (if_redirect_ready_i) begin
                    state_d          = BR_IDLE;
                    redirect_valid_d = 1'b0;
                end
            end
            default: state_d = BR_IDLE;
        endcase
    end

endmodule
